// File: rtl/kalman_gain_seq.sv
// Sequential Kalman gain: K0 = P00*2^13/S then K1 = P10*2^13/S through one shared
// restoring divider. Define KALMAN_GAIN_ROUND_EN for 14-iteration round-half-up gains.
module kalman_gain_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [22:0] S_in,
  input  logic [22:0] P00_in,
  input  logic [22:0] P10_in,
  output logic        busy,
  output logic        done,
  output logic        div0_err,
  output logic        sat,
  output logic [12:0] K0_out,
  output logic [12:0] K1_out,
  output logic [1:0]  o_dbg_state
);

`ifdef KALMAN_GAIN_ROUND_EN
  localparam int N = 14;
`else
  localparam int N = 13;
`endif

  // Handshake: start is accepted only while busy is low (IDLE); busy then stays high
  // until done has pulsed for exactly one cycle, and starts seen while busy are dropped.
  typedef enum logic [1:0] {IDLE = 2'd0, DIV0 = 2'd1, DIV1 = 2'd2, DONE = 2'd3} state_t;

  state_t        r_state;
  logic [22:0]   r_s;
  logic [22:0]   r_p10;
  logic [23:0]   r_rem;
  logic [N-1:0]  r_quo;
  logic [3:0]    r_cnt;
  logic [13:0]   r_k0;
  logic          r_sat0;
  logic          r_sat1;
  logic          r_div0;

  logic [24:0]   w_r2;
  logic          w_ge;
  logic [23:0]   w_sub;
  logic [23:0]   w_rem_nxt;
  logic [N-1:0]  w_quo_nxt;
  logic          w_last;
  logic [13:0]   w_g0;
  logic [13:0]   w_g1;

  // Returns {saturated, gain}; the saturated flag folds in rounding overflow.
  function automatic logic [13:0] f_gain(input logic [N-1:0] q, input logic s);
`ifdef KALMAN_GAIN_ROUND_EN
    logic [13:0] r;
    r = {1'b0, q[N-1:1]} + {13'd0, q[0]};
    if (s || r[13]) f_gain = {1'b1, 13'h1fff};
    else            f_gain = {1'b0, r[12:0]};
`else
    f_gain = s ? {1'b1, 13'h1fff} : {1'b0, q};
`endif
  endfunction

  // Bit 24 of the doubled remainder only matters when the gain is already saturated.
  assign w_r2      = {r_rem, 1'b0};
  assign w_ge      = (w_r2 >= {2'b00, r_s});
  assign w_sub     = w_r2[23:0] - {1'b0, r_s};
  assign w_rem_nxt = w_ge ? w_sub : w_r2[23:0];
  assign w_quo_nxt = {r_quo[N-2:0], w_ge};
  assign w_last    = (r_cnt == 4'(N - 1));
  assign w_g0      = f_gain(w_quo_nxt, r_sat0);
  assign w_g1      = f_gain(w_quo_nxt, r_sat1);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_p10    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_k0     <= '0;
      r_sat0   <= 1'b0;
      r_sat1   <= 1'b0;
      r_div0   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div0_err <= 1'b0;
      sat      <= 1'b0;
      K0_out   <= '0;
      K1_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_s     <= S_in;
            r_p10   <= P10_in;
            r_rem   <= {1'b0, P00_in};
            r_quo   <= '0;
            r_cnt   <= '0;
            r_sat0  <= (P00_in >= S_in);
            r_sat1  <= (P10_in >= S_in);
            r_div0  <= (S_in == 23'd0);
            busy    <= 1'b1;
            r_state <= DIV0;
          end
        end
        DIV0: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_k0    <= w_g0;
            r_rem   <= {1'b0, r_p10};
            r_quo   <= '0;
            r_cnt   <= '0;
            r_state <= DIV1;
          end
        end
        DIV1: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_cnt    <= '0;
            K0_out   <= r_k0[12:0];
            K1_out   <= w_g1[12:0];
            sat      <= r_k0[13] | w_g1[13];
            div0_err <= r_div0;
            done     <= 1'b1;
            r_state  <= DONE;
          end
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kalman_gain_seq.sv
// Bench for kalman_gain_seq: directed and random requests, expected gains queued at
// issue time from a divide-based reference and checked whenever done pulses.
module tb_kalman_gain_seq;

`ifdef KALMAN_GAIN_ROUND_EN
  localparam int N = 14;
`else
  localparam int N = 13;
`endif
  localparam int EW = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [22:0] s_in, p00_in, p10_in;
  logic        busy, done, div0_err, sat;
  logic [12:0] k0_out, k1_out;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];

  kalman_gain_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .S_in(s_in), .P00_in(p00_in), .P10_in(p10_in),
    .busy(busy), .done(done), .div0_err(div0_err), .sat(sat),
    .K0_out(k0_out), .K1_out(k1_out), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: real-valued gain P/S in units of 2^-13, truncated or rounded half-up
  function automatic logic [13:0] ref_gain(input longint unsigned s, input longint unsigned p);
    longint unsigned q;
    if (s == 0 || p >= s) return {1'b1, 13'd8191};
`ifdef KALMAN_GAIN_ROUND_EN
    q = (2 * p * 8192 + s) / (2 * s);
`else
    q = (p * 8192) / s;
`endif
    if (q > 8191) return {1'b1, 13'd8191};
    return {1'b0, q[12:0]};
  endfunction

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic push_exp(input logic [22:0] s, input logic [22:0] p0, input logic [22:0] p1);
    logic [13:0] g0, g1;
    int unsigned due;
    g0 = ref_gain(s, p0);
    g1 = ref_gain(s, p1);
    due = cyc + 2 * N;
    exp_q.push_back({g0[12:0], g1[12:0], (s == 0), g0[13] | g1[13], due});
  endtask

  task automatic issue(input logic [22:0] s, input logic [22:0] p0, input logic [22:0] p1,
                       input bit expect_done);
    @(posedge clk); #1;
    s_in = s; p00_in = p0; p10_in = p1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (expect_done) push_exp(s, p0, p1);
    check("busy_after_start", busy, 1);
    s_in = 23'($urandom); p00_in = 23'($urandom); p10_in = 23'($urandom);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("k0", k0_out, e[59:47]);
        check("k1", k1_out, e[46:34]);
        check("div0_err", div0_err, e[33]);
        check("sat", sat, e[32]);
        check("done_cycle", cyc, e[31:0]);
      end
    end
  end

  initial begin
    logic [22:0] s, p0, p1;
    int n;
    rst = 1'b1; start = 1'b0; s_in = '0; p00_in = '0; p10_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_k0", k0_out, 0);
    check("rst_k1", k1_out, 0);
    check("rst_sat", sat, 0);
    check("rst_div0", div0_err, 0);
    rst = 1'b0;

    issue(23'd8192, 23'd4096, 23'd2048, 1'b1); wait_idle();
    issue(23'd3, 23'd1, 23'd2, 1'b1);          wait_idle();
    issue(23'd100, 23'd100, 23'd50, 1'b1);     wait_idle();
    issue(23'd0, 23'd5, 23'd7, 1'b1);          wait_idle();

    // second start mid-computation is dropped; start held over DONE is taken in IDLE
    issue(23'd1000, 23'd300, 23'd700, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    s_in = 23'd7; p00_in = 23'd1; p10_in = 23'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done, 1);
    s_in = 23'd5000; p00_in = 23'd1234; p10_in = 23'd4321; start = 1'b1;
    @(posedge clk); #1;
    check("busy_in_idle_after_done", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(23'd5000, 23'd1234, 23'd4321);
    check("busy_after_restart", busy, 1);
    wait_idle();

    // reset mid-computation: no done, outputs cleared
    issue(23'd777, 23'd500, 23'd600, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_k0", k0_out, 0);
    check("abort_k1", k1_out, 0);
    check("abort_sat", sat, 0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_busy_later", busy, 0);
    issue(23'd3, 23'd1, 23'd2, 1'b1); wait_idle();

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0:       s = 23'($urandom_range(0, 2));
        1:       s = 23'($urandom_range(1, 64));
        default: s = 23'($urandom_range(1, 32'h7fffff));
      endcase
      p0 = (s == 0 || $urandom_range(0, 4) == 0) ? 23'($urandom) : 23'($urandom_range(0, s - 1));
      p1 = (s == 0 || $urandom_range(0, 4) == 0) ? 23'($urandom) : 23'($urandom_range(0, s - 1));
      issue(s, p0, p1, 1'b1);
      wait_idle();
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kalman_gain_seq.md
KALMAN_GAIN_SEQ -- requirements
Module: kalman_gain_seq

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have port S_in  input  23  innovation covariance S (unsigned), from step 4.
REQ-005 SHALL have port P00_in  input  23  covariance P00 (unsigned), from step 2.
REQ-006 SHALL have port P10_in  input  23  covariance P10 (unsigned), from step 2.
REQ-007 SHALL have port busy  output  1  high while a computation is in progress (DIV0, DIV1, DONE).
REQ-008 SHALL have port done  output  1  one-cycle pulse; K0_out/K1_out updated this cycle.
REQ-009 SHALL have port div0_err  output  1  S_in was 0 for the last completed computation.
REQ-010 SHALL have port sat  output  1  at least one gain saturated in the last completed computation.
REQ-011 SHALL have port K0_out  output  13  Kalman gain K[0], unsigned, 2^-13 per LSB.
REQ-012 SHALL have port K1_out  output  13  Kalman gain K[1], unsigned, 2^-13 per LSB.

Function
REQ-013 SHALL compute Kx = floor(Px*2^13 / S) using ONE shared radix-2 restoring divider, K0 first, then K1.
REQ-014 SHALL have states IDLE, DIV0, DIV1, DONE; IDLE->DIV0 on start; DIV0->DIV1 after N iterations; DIV1->DONE after N iterations; DONE->IDLE unconditionally.
REQ-015 SHALL capture S_in, P00_in, P10_in into internal registers on the edge where start is sampled in IDLE; input changes afterwards SHALL not affect the result.
REQ-016 SHALL perform one divider iteration per DIVx cycle: R = 2R; if R >= S then R = R - S and quotient bit = 1, else bit = 0; remainder register 24 bits wide, R initialised to Px.
REQ-017 SHALL use N = 13 iterations per gain (no macro); done asserted in the 27th cycle after the start-sampling edge; fixed latency regardless of operand values.
REQ-018 SHALL saturate a gain to 8191 when Px >= S (detected at capture), setting sat; the divider still runs its full N cycles.
REQ-019 SHALL force both gains to 8191 and set div0_err and sat when S == 0.
REQ-020 SHALL update K0_out, K1_out, div0_err, sat only on the edge entering DONE; values SHALL hold until the next DONE.
REQ-021 SHALL assert done high in DONE only, exactly one cycle per accepted start.
REQ-022 SHALL ignore start while busy (no restart, no queuing); start in the DONE cycle is ignored; start in the IDLE cycle following DONE is accepted.

Reset
REQ-023 SHALL, on rst high at a rising edge, enter IDLE and clear busy, done, div0_err, sat, K0_out, K1_out, remainder, quotient and counter to 0.
REQ-024 SHALL abort any computation in progress on rst, produce no done pulse and not update outputs with partial results; rst takes priority over start.

Configuration
REQ-025 SHALL, when macro KALMAN_GAIN_ROUND_EN is defined, use N = 14 iterations per gain and round half-up (quotient bit 14 plus LSB), saturating to 8191 on overflow; done in the 29th cycle after start sampling.
REQ-026 SHALL, when KALMAN_GAIN_ROUND_EN is undefined, truncate (REQ-013, REQ-017), bit-exact to the combinational step-5 gain for Px < S.

Verification
REQ-027 SHALL pass: S=8192, P00=4096, P10=2048, start -> done at cycle 27, K0=4096, K1=2048, sat=0, div0_err=0.
REQ-028 SHALL pass: S=3, P00=1, P10=2 -> K0=2730, K1=5461 without macro; K0=2731, K1=5461 with KALMAN_GAIN_ROUND_EN (done at cycle 29).
REQ-029 SHALL pass: S=100, P00=100, P10=50 -> K0=8191, K1=4096, sat=1, div0_err=0.
REQ-030 SHALL pass: S=0, P00=5, P10=7 -> K0=8191, K1=8191, div0_err=1, sat=1, done at cycle 27.
REQ-031 SHALL pass: second start pulse at cycle 10 with different operands -> ignored, single done at cycle 27 with first-request results; start in IDLE after DONE accepted.
REQ-032 SHALL pass: rst asserted at cycle 10 of a computation -> no done pulse, all outputs 0, busy=0 next cycle; subsequent start computes correctly.
